// File: rtl/ts_sync_cc_monitor.sv
// MPEG-2 TS sync acquisition and per-PID continuity-counter monitor.
// Aligns a byte stream on 0x47, forwards packets with sop/eop markers and reports CC errors.
`timescale 1ns/1ps
module ts_sync_cc_monitor #(
  parameter int PKT_LEN   = 188,
  parameter int SYNC_LOCK = 3,
  parameter int SYNC_LOSS = 3,
  parameter int NUM_PIDS  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data_in,
  input  logic                 valid_in,
  output logic [7:0]           data_out,
  output logic                 valid_out,
  output logic                 sop,
  output logic                 eop,
  output logic                 locked,
  output logic                 cc_err,
  output logic [CNT_WIDTH-1:0] cc_err_count,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  localparam int PW = $clog2(PKT_LEN);
  localparam int GW = $clog2(SYNC_LOCK + 1);
  localparam int MW = $clog2(SYNC_LOSS + 1);
  localparam int IW = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [7:0]    SYNC_BYTE = 8'h47;
  localparam logic [12:0]   NULL_PID  = 13'h1FFF;
  localparam logic [PW-1:0] LAST_POS  = PW'(PKT_LEN - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          tei_q, tei_d;
  logic [12:0]   pid_q, pid_d;

  logic [7:0]           data_out_q;
  logic                 valid_out_q, sop_q, eop_q, locked_q, cc_err_q;
  logic [CNT_WIDTH-1:0] cc_err_count_q, pkt_count_q;

  logic [NUM_PIDS-1:0] tbl_valid_q;
  logic [12:0]         tbl_pid_q [NUM_PIDS];
  logic [3:0]          tbl_cc_q  [NUM_PIDS];

  logic          pos_zero, pos_last, is_sync;
  logic [PW-1:0] cnt_inc;
  logic          fwd, clear_tbl;

  assign pos_zero = (byte_cnt_q == '0);
  assign pos_last = (byte_cnt_q == LAST_POS);
  assign is_sync  = (data_in == SYNC_BYTE);
  assign cnt_inc  = pos_last ? '0 : byte_cnt_q + PW'(1);

  // Sync state machine; every transition is gated by valid_in.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    good_d     = good_q;
    miss_d     = miss_q;
    fwd        = 1'b0;
    clear_tbl  = 1'b0;
    if (valid_in) begin
      case (state_q)
        ST_HUNT: begin
          if (is_sync) begin
            state_d    = ST_VERIFY;
            byte_cnt_d = PW'(1);
            good_d     = GW'(1);
          end
        end
        ST_VERIFY: begin
          byte_cnt_d = cnt_inc;
          if (pos_zero) begin
            if (is_sync) begin
              good_d = good_q + GW'(1);
              if (good_q == GW'(SYNC_LOCK - 1)) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
                fwd     = 1'b1;
              end
            end else begin
              state_d    = ST_HUNT;
              byte_cnt_d = '0;
              good_d     = '0;
            end
          end
        end
        ST_LOCKED: begin
          byte_cnt_d = cnt_inc;
          fwd        = 1'b1;
          if (pos_zero) begin
            if (is_sync) begin
              miss_d = '0;
            end else if (miss_q == MW'(SYNC_LOSS - 1)) begin
              state_d    = ST_HUNT;
              byte_cnt_d = '0;
              good_d     = '0;
              miss_d     = '0;
              fwd        = 1'b0;
              clear_tbl  = 1'b1;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end
        default: begin
          state_d    = ST_HUNT;
          byte_cnt_d = '0;
          good_d     = '0;
          miss_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    tei_d = tei_q;
    pid_d = pid_q;
    if (valid_in && state_q == ST_LOCKED) begin
      if (byte_cnt_q == PW'(1)) begin
        tei_d        = data_in[7];
        pid_d[12:8]  = data_in[4:0];
      end else if (byte_cnt_q == PW'(2)) begin
        pid_d[7:0]   = data_in;
      end
    end
  end

  // Continuity check on the byte carrying AFC/CC (position 3).
  logic [NUM_PIDS-1:0] hit_vec, free_vec;
  logic [IW-1:0]       hit_idx, free_idx, wr_idx;
  logic                hit_any, free_any, chk, payload, tbl_wr, cc_err_d;
  logic [3:0]          cc_new, prev_cc, prev_inc;

  generate
    for (genvar gi = 0; gi < NUM_PIDS; gi++) begin : g_match
      assign hit_vec[gi]  = tbl_valid_q[gi] && (tbl_pid_q[gi] == pid_q);
      assign free_vec[gi] = !tbl_valid_q[gi];
    end
  endgenerate

  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUM_PIDS - 1; i >= 0; i--) begin
      if (hit_vec[i])  hit_idx  = IW'(i);
      if (free_vec[i]) free_idx = IW'(i);
    end
  end

  assign hit_any  = |hit_vec;
  assign free_any = |free_vec;
  assign cc_new   = data_in[3:0];
  assign payload  = data_in[4];
  assign prev_cc  = tbl_cc_q[hit_idx];
  assign prev_inc = prev_cc + 4'd1;
  assign chk      = valid_in && (state_q == ST_LOCKED) && (byte_cnt_q == PW'(3))
                    && !tei_q && (pid_q != NULL_PID);

  always_comb begin
    cc_err_d = 1'b0;
    tbl_wr   = 1'b0;
    wr_idx   = free_idx;
    if (chk) begin
      if (hit_any) begin
        wr_idx = hit_idx;
        if (payload) begin
          cc_err_d = (cc_new != prev_inc) && (cc_new != prev_cc);
          tbl_wr   = (cc_new != prev_cc);
        end else begin
          cc_err_d = (cc_new != prev_cc);
        end
      end else if (free_any) begin
        tbl_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_valid_q <= '0;
      for (int i = 0; i < NUM_PIDS; i++) begin
        tbl_pid_q[i] <= '0;
        tbl_cc_q[i]  <= '0;
      end
    end else if (clear_tbl) begin
      tbl_valid_q <= '0;
    end else if (tbl_wr) begin
      tbl_valid_q[wr_idx] <= 1'b1;
      tbl_pid_q[wr_idx]   <= pid_q;
      tbl_cc_q[wr_idx]    <= cc_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      byte_cnt_q <= '0;
      good_q     <= '0;
      miss_q     <= '0;
      tei_q      <= 1'b0;
      pid_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      tei_q      <= tei_d;
      pid_q      <= pid_d;
    end
  end

  // Output stage: strobes are only ever high on cycles that carried a valid byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q     <= '0;
      valid_out_q    <= 1'b0;
      sop_q          <= 1'b0;
      eop_q          <= 1'b0;
      locked_q       <= 1'b0;
      cc_err_q       <= 1'b0;
      cc_err_count_q <= '0;
      pkt_count_q    <= '0;
    end else if (valid_in) begin
      valid_out_q <= fwd;
      sop_q       <= fwd && pos_zero;
      eop_q       <= fwd && pos_last;
      cc_err_q    <= cc_err_d;
      locked_q    <= (state_d == ST_LOCKED);
      if (fwd) data_out_q <= data_in;
      if (fwd && pos_zero) pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
      if (cc_err_d && cc_err_count_q != '1) cc_err_count_q <= cc_err_count_q + CNT_WIDTH'(1);
    end else begin
      valid_out_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      cc_err_q    <= 1'b0;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign sop          = sop_q;
  assign eop          = eop_q;
  assign locked       = locked_q;
  assign cc_err       = cc_err_q;
  assign cc_err_count = cc_err_count_q;
  assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_ts_sync_cc_monitor.sv
// Directed bench for ts_sync_cc_monitor: lock/loss, CC checking, PID table limits, gaps and reset.
`timescale 1ns/1ps
module tb_ts_sync_cc_monitor;
  localparam int PKT_LEN = 188;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0;
  logic [7:0]  data_out;
  logic        valid_out, sop, eop, locked, cc_err;
  logic [15:0] cc_err_count, pkt_count;

  ts_sync_cc_monitor #(
    .PKT_LEN(PKT_LEN), .SYNC_LOCK(3), .SYNC_LOSS(3), .NUM_PIDS(8), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .sop(sop), .eop(eop),
    .locked(locked), .cc_err(cc_err), .cc_err_count(cc_err_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int obs_valid, obs_sop, obs_eop, obs_ccerr, ccerr_pos, sop_pos, eop_pos, idle_bad;
  logic [7:0] sop_data;
  logic sop_locked, pos0_valid, pos0_locked;

  task automatic clear_obs();
    obs_valid = 0; obs_sop = 0; obs_eop = 0; obs_ccerr = 0;
    ccerr_pos = -1; sop_pos = -1; eop_pos = -1; idle_bad = 0;
    sop_data = 8'h00; sop_locked = 1'b0; pos0_valid = 1'b0; pos0_locked = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int pos);
    @(negedge clk);
    data_in = b;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    if (valid_out) obs_valid++;
    if (sop) begin obs_sop++; sop_pos = pos; sop_data = data_out; sop_locked = locked; end
    if (eop) begin obs_eop++; eop_pos = pos; end
    if (cc_err) begin obs_ccerr++; ccerr_pos = pos; end
    if (pos == 0) begin pos0_valid = valid_out; pos0_locked = locked; end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_in = 1'b0;
    data_in = 8'h47;
    @(posedge clk);
    #1;
    if (valid_out || sop || eop || cc_err) idle_bad++;
  endtask

  function automatic logic [7:0] pkt_byte(input logic [7:0] sync, input logic [12:0] pid,
                                          input logic tei, input logic [1:0] afc,
                                          input logic [3:0] cc, input int pos);
    logic [7:0] p;
    p = pos[7:0];
    case (pos)
      0: return sync;
      1: return {tei, 2'b00, pid[12:8]};
      2: return pid[7:0];
      3: return {2'b00, afc, cc};
      default: return (p == 8'h47) ? 8'h00 : p;
    endcase
  endfunction

  task automatic send_pkt(input logic [7:0] sync, input logic [12:0] pid, input logic tei,
                          input logic [1:0] afc, input logic [3:0] cc, input bit gaps);
    clear_obs();
    for (int pos = 0; pos < PKT_LEN; pos++) begin
      send_byte(pkt_byte(sync, pid, tei, afc, cc, pos), pos);
      if (gaps) idle_cycle();
    end
    $display("pkt sync=%h pid=%h tei=%0d afc=%b cc=%0d -> valid=%0d sop=%0d eop=%0d cc_err=%0d locked=%0d pkts=%0d errs=%0d",
             sync, pid, tei, afc, cc, obs_valid, obs_sop, obs_eop, obs_ccerr, locked, pkt_count, cc_err_count);
  endtask

  task automatic good_pkt(input logic [12:0] pid, input logic [3:0] cc);
    send_pkt(8'h47, pid, 1'b0, 2'b01, cc, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", valid_out); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
    total++; if ({sop, eop, cc_err} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {sop, eop, cc_err}); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
    total++; if (pkt_count !== 16'd0 || cc_err_count !== 16'd0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", pkt_count, cc_err_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock();
    good_pkt(13'h100, 4'd0);
    total++; if (obs_valid !== 0 || locked !== 1'b0) begin bad++; $display("FAIL lock_pkt1: got valid=%0d locked=%0b want 0/0", obs_valid, locked); end
    good_pkt(13'h100, 4'd1);
    total++; if (obs_valid !== 0 || locked !== 1'b0) begin bad++; $display("FAIL lock_pkt2: got valid=%0d locked=%0b want 0/0", obs_valid, locked); end
    good_pkt(13'h100, 4'd2);
    total++; if (obs_valid !== PKT_LEN) begin bad++; $display("FAIL lock_pkt3_valid: got %0d want %0d", obs_valid, PKT_LEN); end
    total++; if (obs_sop !== 1 || sop_pos !== 0 || sop_data !== 8'h47) begin bad++; $display("FAIL lock_first_sop: got n=%0d pos=%0d data=%h want 1/0/47", obs_sop, sop_pos, sop_data); end
    total++; if (sop_locked !== 1'b1) begin bad++; $display("FAIL lock_with_sop: got %0b want 1", sop_locked); end
    total++; if (obs_eop !== 1 || eop_pos !== PKT_LEN - 1) begin bad++; $display("FAIL lock_eop: got n=%0d pos=%0d want 1/%0d", obs_eop, eop_pos, PKT_LEN - 1); end
    good_pkt(13'h100, 4'd3);
    good_pkt(13'h100, 4'd4);
    total++; if (obs_ccerr !== 0 || cc_err_count !== 16'd0) begin bad++; $display("FAIL lock_clean_cc: got pulses=%0d count=%0d want 0/0", obs_ccerr, cc_err_count); end
    total++; if (pkt_count !== 16'd3) begin bad++; $display("FAIL lock_pkt_count: got %0d want 3", pkt_count); end
  endtask

  task automatic test_cc_jump();
    good_pkt(13'h100, 4'd5);
    total++; if (obs_ccerr !== 0) begin bad++; $display("FAIL jump_cc5: got %0d want 0", obs_ccerr); end
    good_pkt(13'h100, 4'd7);
    total++; if (obs_ccerr !== 1 || ccerr_pos !== 3) begin bad++; $display("FAIL jump_cc7_pulse: got n=%0d pos=%0d want 1/3", obs_ccerr, ccerr_pos); end
    total++; if (cc_err_count !== 16'd1) begin bad++; $display("FAIL jump_count: got %0d want 1", cc_err_count); end
  endtask

  task automatic test_dup_afc();
    good_pkt(13'h100, 4'd8);
    good_pkt(13'h100, 4'd8);
    total++; if (obs_ccerr !== 0 || cc_err_count !== 16'd1) begin bad++; $display("FAIL dup_no_err: got n=%0d count=%0d want 0/1", obs_ccerr, cc_err_count); end
    send_pkt(8'h47, 13'h100, 1'b0, 2'b10, 4'd9, 1'b0);
    total++; if (obs_ccerr !== 1 || cc_err_count !== 16'd2) begin bad++; $display("FAIL afc10_changed: got n=%0d count=%0d want 1/2", obs_ccerr, cc_err_count); end
    send_pkt(8'h47, 13'h100, 1'b0, 2'b10, 4'd8, 1'b0);
    total++; if (obs_ccerr !== 0) begin bad++; $display("FAIL afc10_same: got %0d want 0", obs_ccerr); end
    good_pkt(13'h100, 4'd9);
    total++; if (obs_ccerr !== 0) begin bad++; $display("FAIL afc10_no_update: got %0d want 0", obs_ccerr); end
    total++; if (pkt_count !== 16'd10) begin bad++; $display("FAIL dup_pkt_count: got %0d want 10", pkt_count); end
  endtask

  task automatic test_sync_loss();
    send_pkt(8'h00, 13'h100, 1'b0, 2'b01, 4'd10, 1'b0);
    total++; if (obs_sop !== 1 || sop_data !== 8'h00 || obs_valid !== PKT_LEN || pos0_locked !== 1'b1) begin bad++; $display("FAIL miss1: got sop=%0d data=%h valid=%0d locked=%0b want 1/00/%0d/1", obs_sop, sop_data, obs_valid, pos0_locked, PKT_LEN); end
    send_pkt(8'h00, 13'h100, 1'b0, 2'b01, 4'd11, 1'b0);
    total++; if (obs_sop !== 1 || obs_valid !== PKT_LEN || pos0_locked !== 1'b1) begin bad++; $display("FAIL miss2: got sop=%0d valid=%0d locked=%0b want 1/%0d/1", obs_sop, obs_valid, pos0_locked, PKT_LEN); end
    send_pkt(8'h00, 13'h100, 1'b0, 2'b01, 4'd12, 1'b0);
    total++; if (pos0_valid !== 1'b0 || pos0_locked !== 1'b0) begin bad++; $display("FAIL miss3_drop: got valid=%0b locked=%0b want 0/0", pos0_valid, pos0_locked); end
    total++; if (obs_valid !== 0) begin bad++; $display("FAIL miss3_hunt: got %0d bytes want 0", obs_valid); end
    total++; if (pkt_count !== 16'd12) begin bad++; $display("FAIL miss_pkt_count: got %0d want 12", pkt_count); end
    good_pkt(13'h100, 4'd0);
    good_pkt(13'h100, 4'd1);
    total++; if (obs_valid !== 0 || locked !== 1'b0) begin bad++; $display("FAIL relock_early: got valid=%0d locked=%0b want 0/0", obs_valid, locked); end
    good_pkt(13'h100, 4'd5);
    total++; if (obs_valid !== PKT_LEN || locked !== 1'b1 || obs_ccerr !== 0) begin bad++; $display("FAIL relock: got valid=%0d locked=%0b err=%0d want %0d/1/0", obs_valid, locked, obs_ccerr, PKT_LEN); end
    total++; if (pkt_count !== 16'd13 || cc_err_count !== 16'd2) begin bad++; $display("FAIL relock_counts: got %0d/%0d want 13/2", pkt_count, cc_err_count); end
  endtask

  task automatic test_pid_table();
    int errs;
    errs = 0;
    for (int k = 1; k <= 9; k++) begin
      good_pkt(13'h200 + 13'(k), 4'd0);
      errs += obs_ccerr;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL pid_fill: got %0d errs want 0", errs); end
    good_pkt(13'h209, 4'd5);
    total++; if (obs_ccerr !== 0) begin bad++; $display("FAIL pid9_jump: got %0d want 0", obs_ccerr); end
    good_pkt(13'h208, 4'd9);
    total++; if (obs_ccerr !== 0) begin bad++; $display("FAIL pid8_jump: got %0d want 0", obs_ccerr); end
    good_pkt(13'h1FFF, 4'd0);
    good_pkt(13'h1FFF, 4'd9);
    total++; if (obs_ccerr !== 0) begin bad++; $display("FAIL null_pid_jump: got %0d want 0", obs_ccerr); end
    send_pkt(8'h47, 13'h201, 1'b1, 2'b01, 4'd7, 1'b0);
    total++; if (obs_ccerr !== 0) begin bad++; $display("FAIL tei_jump: got %0d want 0", obs_ccerr); end
    good_pkt(13'h201, 4'd3);
    total++; if (obs_ccerr !== 1 || cc_err_count !== 16'd3) begin bad++; $display("FAIL pid1_jump: got n=%0d count=%0d want 1/3", obs_ccerr, cc_err_count); end
    good_pkt(13'h201, 4'd4);
    total++; if (obs_ccerr !== 0) begin bad++; $display("FAIL pid1_after_err: got %0d want 0", obs_ccerr); end
    total++; if (pkt_count !== 16'd29) begin bad++; $display("FAIL pid_pkt_count: got %0d want 29", pkt_count); end
  endtask

  task automatic test_gaps();
    send_pkt(8'h47, 13'h100, 1'b0, 2'b01, 4'd7, 1'b1);
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL gap_idle_strobes: got %0d want 0", idle_bad); end
    total++; if (obs_valid !== PKT_LEN || obs_sop !== 1 || obs_eop !== 1) begin bad++; $display("FAIL gap_framing: got %0d/%0d/%0d want %0d/1/1", obs_valid, obs_sop, obs_eop, PKT_LEN); end
    total++; if (obs_ccerr !== 1 || ccerr_pos !== 3) begin bad++; $display("FAIL gap_cc_err: got n=%0d pos=%0d want 1/3", obs_ccerr, ccerr_pos); end
    total++; if (pkt_count !== 16'd30 || cc_err_count !== 16'd4) begin bad++; $display("FAIL gap_counts: got %0d/%0d want 30/4", pkt_count, cc_err_count); end
  endtask

  task automatic test_mid_reset();
    clear_obs();
    for (int pos = 0; pos < 50; pos++) send_byte(pkt_byte(8'h47, 13'h100, 1'b0, 2'b01, 4'd8, pos), pos);
    total++; if (valid_out !== 1'b1 || locked !== 1'b1) begin bad++; $display("FAIL pre_reset: got valid=%0b locked=%0b want 1/1", valid_out, locked); end
    @(negedge clk);
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (valid_out !== 1'b0 || locked !== 1'b0 || data_out !== 8'h00) begin bad++; $display("FAIL async_reset_out: got %0b/%0b/%h want 0/0/00", valid_out, locked, data_out); end
    total++; if (pkt_count !== 16'd0 || cc_err_count !== 16'd0) begin bad++; $display("FAIL async_reset_counts: got %0d/%0d want 0/0", pkt_count, cc_err_count); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    good_pkt(13'h100, 4'd9);
    total++; if (obs_valid !== 0 || locked !== 1'b0 || pkt_count !== 16'd0) begin bad++; $display("FAIL post_reset_hunt: got valid=%0d locked=%0b pkts=%0d want 0/0/0", obs_valid, locked, pkt_count); end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_lock();
    test_cc_jump();
    test_dup_afc();
    test_sync_loss();
    test_pid_table();
    test_gaps();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
